conv_window_anchor_gen: RTL

//  Parametrised successor to the 2D conv anchor generator. Emits the top-left input

---
 rtl/conv_anchor_pkg.sv | 26 ++
 rtl/anchor_axis_stepper.sv | 63 ++++++
 rtl/conv_window_anchor_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_anchor_pkg.sv
// Shared state encoding and geometry helpers for the conv window anchor generator.
package conv_anchor_pkg;

    localparam int COORD_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } anchor_state_e;

    // Output positions along one axis; 0 when the padded input is smaller than the kernel.
    function automatic int conv_out_dim(input int in_dim, input int k, input int s, input int p);
        int span;
        span = in_dim + 2 * p - k;
        if (span < 0 || s < 1) begin
            return 0;
        end
        return span / s + 1;
    endfunction

    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/anchor_axis_stepper.sv
// One output axis: position index plus the signed input coordinate it maps to.
// The coordinate is accumulated by STEP so no multiplier is needed.
module anchor_axis_stepper
    import conv_anchor_pkg::*;
#(
    parameter int COUNT   = 1,
    parameter int START   = 0,
    parameter int STEP    = 1,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      adv_i,
    output logic signed [COORD_W-1:0] coord_o,
    output logic signed [COORD_W-1:0] coord_d_o,
    output logic                      last_o,
    output logic                      last_d_o
);

    localparam int                         IDX_W    = idx_width(COUNT);
    localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(COUNT - 1);
    localparam logic signed [COORD_W-1:0]  START_C  = COORD_W'(START);
    localparam logic signed [COORD_W-1:0]  STEP_C   = COORD_W'(STEP);

    logic [IDX_W-1:0]          idx_q;
    logic [IDX_W-1:0]          idx_d;
    logic signed [COORD_W-1:0] coord_q;
    logic signed [COORD_W-1:0] coord_d;

    always_comb begin
        idx_d   = idx_q;
        coord_d = coord_q;
        if (clear_i) begin
            idx_d   = '0;
            coord_d = START_C;
        end else if (adv_i) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                coord_d = START_C;
            end else begin
                idx_d   = idx_q + 1'b1;
                coord_d = coord_q + STEP_C;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            coord_q <= START_C;
        end else begin
            idx_q   <= idx_d;
            coord_q <= coord_d;
        end
    end

    assign coord_o   = coord_q;
    assign coord_d_o = coord_d;
    assign last_o    = (idx_q == LAST_IDX);
    assign last_d_o  = (idx_d == LAST_IDX);

endmodule

// File: rtl/conv_window_anchor_gen.sv
// Streams the top-left input coordinate and channel of every conv window in
// raster order (channel outer, row, column inner) over a valid/ready handshake.
module conv_window_anchor_gen
    import conv_anchor_pkg::*;
#(
    parameter int IN_H     = 28,
    parameter int IN_W     = 28,
    parameter int K_H      = 3,
    parameter int K_W      = 3,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1,
    parameter int PAD_H    = 1,
    parameter int PAD_W    = 1,
    parameter int CH       = 1,
    parameter int COORD_W  = COORD_W_DEFAULT,
    localparam int CH_W    = idx_width(CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      anchor_ready,
    output logic                      anchor_valid,
    output logic signed [COORD_W-1:0] anchor_row,
    output logic signed [COORD_W-1:0] anchor_col,
    output logic [CH_W-1:0]           anchor_ch,
    output logic                      anchor_pad,
    output logic                      anchor_eol,
    output logic                      anchor_last,
    output logic                      done
);

    localparam int OUT_H = conv_out_dim(IN_H, K_H, STRIDE_H, PAD_H);
    localparam int OUT_W = conv_out_dim(IN_W, K_W, STRIDE_W, PAD_W);

    // A window overlaps bottom/right padding once its origin passes these limits.
    localparam logic signed [COORD_W-1:0] ROW_MAX = COORD_W'(IN_H - K_H);
    localparam logic signed [COORD_W-1:0] COL_MAX = COORD_W'(IN_W - K_W);
    localparam logic [CH_W-1:0]           CH_LAST = CH_W'(CH - 1);

    if (OUT_H < 1 || OUT_W < 1) begin : g_bad_geometry
        $error("conv_window_anchor_gen: output map is empty (OUT_H=%0d OUT_W=%0d)", OUT_H, OUT_W);
    end
    if (STRIDE_H < 1 || STRIDE_W < 1 || CH < 1) begin : g_bad_params
        $error("conv_window_anchor_gen: strides and channel count must be >= 1");
    end

    anchor_state_e state_q;
    anchor_state_e state_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          pad_q, pad_d;
    logic          eol_q, eol_d;
    logic          last_q, last_d;
    logic [CH_W-1:0] ch_q, ch_d;

    logic clear;
    logic load_flags;
    logic col_adv;
    logic row_adv;
    logic ch_adv;
    logic xfer;

    logic signed [COORD_W-1:0] row_coord, row_coord_d;
    logic signed [COORD_W-1:0] col_coord, col_coord_d;
    logic                      row_last, row_last_d;
    logic                      col_last, col_last_d;

    assign xfer    = valid_q & anchor_ready;
    assign row_adv = col_adv & col_last;
    assign ch_adv  = row_adv & row_last;

    anchor_axis_stepper #(
        .COUNT   (OUT_W),
        .START   (-PAD_W),
        .STEP    (STRIDE_W),
        .COORD_W (COORD_W)
    ) u_col_stepper (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .adv_i     (col_adv),
        .coord_o   (col_coord),
        .coord_d_o (col_coord_d),
        .last_o    (col_last),
        .last_d_o  (col_last_d)
    );

    anchor_axis_stepper #(
        .COUNT   (OUT_H),
        .START   (-PAD_H),
        .STEP    (STRIDE_H),
        .COORD_W (COORD_W)
    ) u_row_stepper (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .adv_i     (row_adv),
        .coord_o   (row_coord),
        .coord_d_o (row_coord_d),
        .last_o    (row_last),
        .last_d_o  (row_last_d)
    );

    // Sequencing: enable low overrides everything and drops any pending anchor.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        done_d     = done_q;
        clear      = 1'b0;
        col_adv    = 1'b0;
        load_flags = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_RUN;
                    valid_d    = 1'b1;
                    load_flags = 1'b1;
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (last_q) begin
                            state_d = ST_FIN;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            col_adv    = 1'b1;
                            load_flags = 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Flags derive from the next coordinates so they register alongside them.
    always_comb begin
        ch_d   = ch_q;
        pad_d  = pad_q;
        eol_d  = eol_q;
        last_d = last_q;
        if (clear) begin
            ch_d = '0;
        end else if (ch_adv) begin
            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        end
        if (clear) begin
            pad_d  = 1'b0;
            eol_d  = 1'b0;
            last_d = 1'b0;
        end else if (load_flags) begin
            pad_d  = row_coord_d[COORD_W-1] | col_coord_d[COORD_W-1] |
                     (row_coord_d > ROW_MAX) | (col_coord_d > COL_MAX);
            eol_d  = col_last_d;
            last_d = col_last_d & row_last_d & (ch_d == CH_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            pad_q   <= 1'b0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            pad_q   <= pad_d;
            eol_q   <= eol_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
        end
    end

    assign anchor_valid = valid_q;
    assign anchor_row   = row_coord;
    assign anchor_col   = col_coord;
    assign anchor_ch    = ch_q;
    assign anchor_pad   = pad_q;
    assign anchor_eol   = eol_q;
    assign anchor_last  = last_q;
    assign done         = done_q;

endmodule
